// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: synthetic crank tooth-wheel generator.
// Emits a tooth train of TEETH slots per revolution. The last GAP slots
// of each revolution are missing teeth. Slot length and tooth high time
// are given in clk cycles and are re-sampled only at slot boundaries.
module crank_wheel_gen #(
   parameter int WIDTH = 24,
   parameter int TEETH = 60,
   parameter int GAP   = 2,
   localparam int TN_W = (TEETH > 1) ? $clog2(TEETH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] high_time,
   output logic             tooth,
   output logic [TN_W-1:0]  tooth_num,
   output logic             gap,
   output logic             rev
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [TN_W-1:0] LAST_SLOT = TN_W'(TEETH - 1);
   localparam logic [TN_W-1:0] FIRST_GAP = TN_W'(TEETH - GAP);

   // Slot length never drops below 2 so a real tooth always has a low cycle.
   function automatic logic [WIDTH-1:0] clamp_per(input logic [WIDTH-1:0] p);
      return (p < WIDTH'(2)) ? WIDTH'(2) : p;
   endfunction

   // High time is forced into 1..per-1 so a real tooth is always visible.
   function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] h,
                                                   input logic [WIDTH-1:0] per);
      logic [WIDTH-1:0] t;
      t = (h == '0) ? WIDTH'(1) : h;
      return (t > per - WIDTH'(1)) ? (per - WIDTH'(1)) : t;
   endfunction

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_per;
   logic [WIDTH-1:0] r_high;
   logic [TN_W-1:0]  r_slot;
   logic             r_tooth;
   logic             r_gap;
   logic             r_rev;

   state_t           w_state;
   logic [WIDTH-1:0] w_cnt;
   logic [WIDTH-1:0] w_per;
   logic [WIDTH-1:0] w_high;
   logic [TN_W-1:0]  w_slot;
   logic             w_tooth;
   logic             w_gap;
   logic             w_rev;

   logic [WIDTH-1:0] w_per_in;
   logic [WIDTH-1:0] w_high_in;
   logic [WIDTH-1:0] w_cnt_inc;
   logic [TN_W-1:0]  w_slot_inc;
   logic             w_boundary;
   logic             w_next_real;

   assign w_per_in    = clamp_per(period);
   assign w_high_in   = clamp_high(high_time, w_per_in);
   assign w_cnt_inc   = r_cnt + WIDTH'(1);
   assign w_boundary  = (r_cnt == r_per - WIDTH'(1));
   assign w_slot_inc  = (r_slot == LAST_SLOT) ? '0 : r_slot + TN_W'(1);
   assign w_next_real = (w_slot_inc < FIRST_GAP);

   // Next-state and next-output logic; ena low leaves everything at its default (hold).
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_per   = r_per;
      w_high  = r_high;
      w_slot  = r_slot;
      w_tooth = r_tooth;
      w_gap   = r_gap;
      w_rev   = r_rev;
      case (r_state)
         S_IDLE: begin
            if (ena) begin
               w_state = S_RUN;
               w_per   = w_per_in;
               w_high  = w_high_in;
               w_cnt   = '0;
               w_slot  = '0;
               w_tooth = 1'b1;
               w_rev   = 1'b1;
               w_gap   = 1'b0;
            end
         end
         S_RUN: begin
            if (ena) begin
               if (w_boundary) begin
                  w_cnt   = '0;
                  w_slot  = w_slot_inc;
                  w_per   = w_per_in;
                  w_high  = w_high_in;
                  w_tooth = w_next_real;
                  w_gap   = !w_next_real;
                  w_rev   = (w_slot_inc == '0);
               end else begin
                  w_cnt   = w_cnt_inc;
                  w_tooth = (w_cnt_inc < r_high) && (r_slot < FIRST_GAP);
                  w_rev   = 1'b0;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_per   <= WIDTH'(2);
         r_high  <= WIDTH'(1);
         r_slot  <= '0;
         r_tooth <= 1'b0;
         r_gap   <= 1'b0;
         r_rev   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_per   <= w_per;
         r_high  <= w_high;
         r_slot  <= w_slot;
         r_tooth <= w_tooth;
         r_gap   <= w_gap;
         r_rev   <= w_rev;
      end
   end

   assign tooth     = r_tooth;
   assign tooth_num = r_slot;
   assign gap       = r_gap;
   assign rev       = r_rev;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Testbench for crank_wheel_gen: a slot-level reference model feeds a
// scoreboard for a 60-2 wheel under directed and random stimulus; a
// second 4-1 wheel is checked against its closed-form tooth pattern.
module tb_crank_wheel_gen;

   localparam int WIDTH = 24;
   localparam int TEETH = 60;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst, ena;
   logic [WIDTH-1:0] period, high_time;
   logic             tooth, gap, rev;
   logic [5:0]       tooth_num;

   logic             rst2, ena2;
   logic [WIDTH-1:0] period2, high_time2;
   logic             tooth2, gap2, rev2;
   logic [1:0]       tooth_num2;

   int n_chk  = 0;
   int n_pass = 0;
   bit done2  = 1'b0;

   always #5 clk = ~clk;

   crank_wheel_gen #(.WIDTH(WIDTH), .TEETH(TEETH), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .ena(ena), .period(period), .high_time(high_time),
      .tooth(tooth), .tooth_num(tooth_num), .gap(gap), .rev(rev));

   crank_wheel_gen #(.WIDTH(WIDTH), .TEETH(4), .GAP(1)) dut2 (
      .clk(clk), .rst(rst2), .ena(ena2), .period(period2), .high_time(high_time2),
      .tooth(tooth2), .tooth_num(tooth_num2), .gap(gap2), .rev(rev2));

   typedef struct packed {
      logic       t;
      logic [5:0] n;
      logic       g;
      logic       r;
   } exp_t;

   exp_t m_cur = '0;
   exp_t m_slotq[$];
   exp_t sb[$];
   bit   m_running = 1'b0;
   int   m_slot = 0;

   // Expand one whole slot into its cycle-by-cycle waveform.
   task automatic build_slot(input int s);
      int  p, h;
      bit  real_t;
      exp_t e;
      p = (int'(period) < 2) ? 2 : int'(period);
      h = (int'(high_time) < 1) ? 1 : int'(high_time);
      if (h > p - 1) h = p - 1;
      real_t = (s < TEETH - GAP);
      for (int k = 0; k < p; k++) begin
         e.t = real_t && (k < h);
         e.n = 6'(s);
         e.g = !real_t;
         e.r = (k == 0) && (s == 0);
         m_slotq.push_back(e);
      end
   endtask

   // Reference model: one expected output per clock edge goes to the scoreboard.
   always @(posedge clk) begin
      if (rst) begin
         m_cur     = '0;
         m_running = 1'b0;
         m_slotq.delete();
      end else if (ena) begin
         if (!m_running) begin
            m_running = 1'b1;
            m_slot    = 0;
            build_slot(0);
         end else if (m_slotq.size() == 0) begin
            m_slot = (m_slot + 1) % TEETH;
            build_slot(m_slot);
         end
         m_cur = m_slotq.pop_front();
      end
      sb.push_back(m_cur);
   end

   // Monitor: compare DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {tooth, tooth_num, gap, rev};
         n_chk++;
         if (a === e) n_pass++;
         else $display("FAIL wheel60 t=%0t got tooth=%b num=%0d gap=%b rev=%b exp tooth=%b num=%0d gap=%b rev=%b",
                       $time, a.t, a.n, a.g, a.r, e.t, e.n, e.g, e.r);
      end
   end

   task automatic step(input bit r, input bit e, input int p, input int h, input int n);
      rst       = r;
      ena       = e;
      period    = WIDTH'(p);
      high_time = WIDTH'(h);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Small 4-1 wheel: pattern 100 100 100 000, 12-cycle revolution.
   initial begin
      int  k;
      bit  et, eg, er;
      int  en;
      rst2 = 1'b1; ena2 = 1'b0; period2 = WIDTH'(3); high_time2 = WIDTH'(1);
      @(negedge clk);
      n_chk++;
      if ({tooth2, tooth_num2, gap2, rev2} === 5'b0) n_pass++;
      else $display("FAIL wheel4_reset got %b exp 00000", {tooth2, tooth_num2, gap2, rev2});
      #1; rst2 = 1'b0; ena2 = 1'b1;
      for (k = 0; k < 36; k++) begin
         @(negedge clk);
         en = (k / 3) % 4;
         et = (k % 3 == 0) && (en != 3);
         eg = (en == 3);
         er = (k % 12 == 0);
         n_chk++;
         if (tooth2 === et && tooth_num2 === 2'(en) && gap2 === eg && rev2 === er) n_pass++;
         else $display("FAIL wheel4 k=%0d got t/n/g/r=%b/%0d/%b/%b exp %b/%0d/%b/%b",
                       k, tooth2, tooth_num2, gap2, rev2, et, en, eg, er);
      end
      done2 = 1'b1;
   end

   initial begin
      rst = 1'b1; ena = 1'b0; period = WIDTH'(10); high_time = WIDTH'(5);
      repeat (3) @(negedge clk);
      #1;
      // nominal 60-2, two full revolutions
      step(0, 1, 10, 5, 1250);
      // mid-slot period change at cnt=3 of slot 5
      step(1, 0, 10, 5, 2);
      step(0, 1, 10, 5, 54);
      step(0, 1, 20, 5, 300);
      // freeze during slot 12 while tooth is high, then reset in slot 40
      step(1, 0, 10, 5, 2);
      step(0, 1, 10, 5, 122);
      step(0, 0, 10, 5, 7);
      step(0, 1, 10, 5, 283);
      step(1, 1, 10, 5, 1);
      step(0, 0, 10, 5, 3);
      step(0, 1, 10, 5, 50);
      // clamp cases
      step(1, 0, 1, 7, 2);
      step(0, 1, 1, 7, 30);
      step(0, 1, 8, 0, 50);
      step(0, 1, 8, 8, 50);
      // random phase
      for (int i = 0; i < 3000; i++) begin
         bit r, e;
         int p, h;
         r = ($urandom_range(0, 499) == 0);
         e = ($urandom_range(0, 3) != 0);
         p = int'(period);
         h = int'(high_time);
         if ($urandom_range(0, 19) == 0) begin
            p = $urandom_range(0, 12);
            h = $urandom_range(0, 13);
         end
         step(r, e, p, h, 1);
      end
      step(0, 0, 10, 5, 3);
      n_chk++;
      if (done2) n_pass++;
      else $display("FAIL wheel4_done got 0 exp 1");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Synthetic crank tooth-wheel signal generator: drives a single-line tooth train with a missing-tooth gap (e.g. 60-2) at a programmable tooth period. It is the transmitting end of the HWAG capture path. Its `tooth` output feeds the same input the capture/gap-search/period-normal logic consumes, for bench self-test and engine-less bring-up. One clock domain; tooth timing is counted in `clk` cycles.

## Interface
- `WIDTH`, 24: width of the period and high-time counters and inputs.
- `TEETH`, 60: tooth slots per revolution, real and missing. Legal range 3..255.
- `GAP`, 2: missing slots at the end of each revolution. Legal range 1..`TEETH`-2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  run enable; low freezes all state and outputs.
- `period`  in  `WIDTH`  tooth slot length in clk cycles; sampled only at slot boundaries.
- `high_time`  in  `WIDTH`  cycles `tooth` stays high within a real slot; sampled with `period`.
- `tooth`  out  1  generated tooth signal, registered.
- `tooth_num`  out  $clog2(`TEETH`)  current slot index, 0..`TEETH`-1.
- `gap`  out  1  high while the current slot is a missing slot (`tooth_num` >= `TEETH`-`GAP`).
- `rev`  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- FSM states are IDLE and RUN. `rst` forces IDLE from any state, including mid-slot.
- Reset values: `tooth`=0, `tooth_num`=0, `gap`=0, `rev`=0. Internal `cnt`=0, `per_l`=2, `high_l`=1.
- Clamping is applied at latch time:
  - `per_l` = max(`period`, 2).
  - `high_l` = min(max(`high_time`, 1), `per_l`-1).
  - Result: every real tooth has at least 1 high cycle and at least 1 low cycle.
- IDLE with `ena`=1:
  - Latch `per_l` and `high_l`.
  - Set `cnt`=0, slot=0, `tooth`=1, `rev`=1, `gap`=0.
  - Go to RUN.
- IDLE with `ena`=0: hold.
- RUN with `ena`=0: hold every register. Outputs keep their values, and `rev` is held too, so a frozen pulse stays visible. Enable gating is the only stall mechanism.
- RUN with `ena`=1 and `cnt` == `per_l`-1 (slot boundary):
  - `cnt`=0.
  - slot = slot+1, wrapping from `TEETH`-1 to 0.
  - Re-latch `per_l` and `high_l` from the inputs.
  - `tooth` = (new slot < `TEETH`-`GAP`).
  - `gap` = !`tooth`.
  - `rev` = (new slot == 0).
- RUN with `ena`=1 otherwise:
  - `cnt` = `cnt`+1.
  - `tooth` = (`cnt`+1 < `high_l`) && (slot < `TEETH`-`GAP`).
  - `rev`=0.
  - `gap` unchanged.
- `cnt` compare and increment are `WIDTH` bits wide. Because `cnt` never exceeds `per_l`-1 <= 2^`WIDTH`-2, no overflow is possible.
- `period` and `high_time` changes mid-slot are ignored until the next boundary. There are no glitch or partial-slot effects.
- Simultaneous `rst` and `ena`: `rst` wins.

## Timing
- Latency from the first enabled edge in IDLE to `tooth`=1 is 1 cycle (registered).
- Real slot: `tooth` is high for exactly `high_l` cycles, then low for `per_l`-`high_l` cycles.
- Missing slot: `tooth` is low for `per_l` cycles.
- Revolution length is `TEETH`×`per_l` cycles at constant period.
- Spacing between `tooth` rising edges:
  - `per_l` between real teeth.
  - (`GAP`+1)×`per_l` across the gap.
- `tooth_num`, `gap` and `rev` change on the same edge as the slot's first `tooth` value.
- With `ena` toggling, every interval above is measured in enabled cycles.

## Test plan
- Nominal 60-2, `period`=10, `high_time`=5, `ena`=1 after reset:
  - Rising edges 10 cycles apart for slots 0..57, each high for 5 cycles.
  - Rising-edge spacing of 30 from slot 57 to the next slot 0.
  - `gap`=1 for exactly 20 cycles.
  - `rev` pulses every 600 cycles.
  - The gap criterion (previous period < gap period / 2, i.e. 10 < 15) holds at every revolution.
- Clamp:
  - `period`=1, `high_time`=7 gives a 2-cycle slot with 1 high cycle and 1 low cycle.
  - `period`=8, `high_time`=0 gives a high time of 1.
  - `period`=8, `high_time`=8 gives a high time of 7.
- Mid-slot change: at `cnt`=3 of slot 5 with `period`=10, switch `period` to 20. Slot 5 still lasts 10 cycles, and slot 6 onward lasts 20.
- Freeze: deassert `ena` for 7 cycles during slot 12 while `tooth` is high. All outputs hold. After re-enable the slot finishes its remaining cycles, so the slot is 10 enabled cycles and 17 wall cycles.
- Reset mid-run: assert `rst` in slot 40. The next cycle shows `tooth`=0, `tooth_num`=0, `gap`=0, `rev`=0. Releasing with `ena`=1 restarts at slot 0 with a `rev` pulse.
- Small wheel, `TEETH`=4, `GAP`=1, `period`=3, `high_time`=1: the `tooth` pattern 100 100 100 000 repeats with a 12-cycle revolution, and `tooth_num` wraps 3 to 0.
